onehot_serial_encoder: RTL and testbench

- Inverse companion to the team's 2-to-4 / 3-to-8 decoders.
- Accepts a WIDTH-bit vector on a valid/ready input and emits the binary index of every set bit as a stream of codes on a valid/ready output, one code per beat, with a last marker.
- One-hot vectors produce one beat. Multi-hot vectors are serialised in priority order. An all-zero vector produces one flagged beat.
- Sits between request/flag collectors and index-driven logic, for example where decoder outputs are fed back.

---
 rtl/onehot_enc_pkg.sv | 8 +
 rtl/onehot_serial_encoder_bit_index_finder.sv | 42 ++++
 rtl/onehot_serial_encoder.sv | 93 +++++++++
 tb/tb_onehot_serial_encoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_enc_pkg.sv
// Shared types and defaults for the one-hot / multi-hot serial index encoder.
package onehot_enc_pkg;

  typedef enum logic {IDLE, EMIT} enc_state_t;

  localparam int ENC_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/onehot_serial_encoder_bit_index_finder.sv
// Combinational priority finder: index of the lowest (or highest) set bit,
// plus flags for "any bit set" and "at most one bit set".
module bit_index_finder
  import onehot_enc_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CODE_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic              single
);

  logic found;

  // The found flag freezes idx at the first set bit met in the scan direction.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (LSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!found && vec[i]) begin
          idx   = CODE_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (!found && vec[i]) begin
          idx   = CODE_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign any    = |vec;
  assign single = ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/onehot_serial_encoder.sv
// Serialises every set bit of an accepted vector into a stream of binary
// indices with a last marker; an all-zero vector yields one flagged beat.
module onehot_serial_encoder
  import onehot_enc_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              out_zero
);

  enc_state_t        state, state_next;
  logic [WIDTH-1:0]  pending, pending_next;
  logic              zero_r, zero_next;
  logic              ready_en;
  logic              accept, xfer;
  logic [CODE_W-1:0] next_idx;
  logic              next_any, next_single;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_en && ((state == IDLE) || (out_valid && out_ready && out_last));
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // A new vector may only be accepted in IDLE or on the final beat's transfer,
  // so accept takes priority and covers the back-to-back case.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    zero_next    = zero_r;
    if (accept) begin
      pending_next = in_vec;
      zero_next    = 1'b0;
      state_next   = EMIT;
    end else if (xfer) begin
      if (!out_last) begin
        pending_next[out_code] = 1'b0;
      end else begin
        pending_next = '0;
        zero_next    = 1'b0;
        state_next   = IDLE;
      end
    end
    if (accept) begin
      zero_next = ~next_any;
    end
  end

  bit_index_finder #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_finder (
    .vec    (pending_next),
    .idx    (next_idx),
    .any    (next_any),
    .single (next_single)
  );

  // Outputs are registered from the next pending vector, so a beat appears
  // right after the accepting edge with no combinational path from in_vec.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      zero_r    <= 1'b0;
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_last  <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      zero_r    <= zero_next;
      ready_en  <= 1'b1;
      out_valid <= (state_next == EMIT);
      out_code  <= (state_next == EMIT) ? next_idx : '0;
      out_last  <= (state_next == EMIT) && next_single;
      out_zero  <= (state_next == EMIT) && zero_next;
    end
  end

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Directed bench for onehot_serial_encoder: LSB-first and MSB-first instances
// share stimulus and are checked every cycle against a beat-queue model.
module tb_onehot_serial_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = 8'h00;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, out_last, out_zero;
  logic [2:0] out_code;
  logic       m_in_ready, m_out_valid, m_out_last, m_out_zero;
  logic [2:0] m_out_code;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int lsb;
    int msb;
    bit last;
    bit zero;
  } beat_t;

  beat_t q[$];
  bit    model_ready_en = 1'b0;

  always #5 clk = ~clk;

  onehot_serial_encoder #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .out_zero  (out_zero)
  );

  onehot_serial_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (m_in_ready),
    .in_vec    (in_vec),
    .out_valid (m_out_valid),
    .out_ready (out_ready),
    .out_code  (m_out_code),
    .out_last  (m_out_last),
    .out_zero  (m_out_zero)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] vec, input logic valid);
    @(negedge clk);
    in_vec   = vec;
    in_valid = valid;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  // Expand a vector into its list of beats from the set-bit positions.
  function automatic void pushVector(input logic [7:0] v);
    int    pos[$];
    beat_t b;
    for (int i = 0; i < 8; i++) if (v[i]) pos.push_back(i);
    if (pos.size() == 0) begin
      b.lsb = 0; b.msb = 0; b.last = 1'b1; b.zero = 1'b1;
      q.push_back(b);
    end else begin
      for (int j = 0; j < pos.size(); j++) begin
        b.lsb  = pos[j];
        b.msb  = pos[pos.size() - 1 - j];
        b.last = (j == pos.size() - 1);
        b.zero = 1'b0;
        q.push_back(b);
      end
    end
  endfunction

  // Model update on each edge, then compare both instances just after it.
  initial begin
    forever begin
      bit exp_ready, mv;
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        model_ready_en = 1'b0;
      end else begin
        exp_ready = model_ready_en && (q.size() == 0 || (out_ready && q[0].last));
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) pushVector(in_vec);
        model_ready_en = 1'b1;
      end
      #1;
      mv = (q.size() != 0);
      checkOutput("out_valid", out_valid, mv);
      checkOutput("msb_out_valid", m_out_valid, mv);
      checkOutput("out_code", out_code, mv ? q[0].lsb : 0);
      checkOutput("msb_out_code", m_out_code, mv ? q[0].msb : 0);
      checkOutput("out_last", out_last, mv ? q[0].last : 1'b0);
      checkOutput("msb_out_last", m_out_last, mv ? q[0].last : 1'b0);
      checkOutput("out_zero", out_zero, mv ? q[0].zero : 1'b0);
      checkOutput("msb_out_zero", m_out_zero, mv ? q[0].zero : 1'b0);
      exp_ready = model_ready_en && rst_n && (!mv || (out_ready && q[0].last));
      checkOutput("in_ready", in_ready, exp_ready);
      checkOutput("msb_in_ready", m_in_ready, exp_ready);
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    afterEdge();
    checkOutput("post_rst_in_ready", in_ready, 1);

    // One-hot
    applyStimulus(8'b0001_0000, 1'b1);
    afterEdge();
    checkOutput("t1_code", out_code, 4);
    checkOutput("t1_last", out_last, 1);
    checkOutput("t1_zero", out_zero, 0);
    checkOutput("t1_in_ready", in_ready, 1);
    applyStimulus(8'h00, 1'b0);
    afterEdge();

    // Multi-hot
    applyStimulus(8'b1000_0101, 1'b1);
    afterEdge();
    checkOutput("t2_code0", out_code, 0);
    checkOutput("t2_msb_code0", m_out_code, 7);
    checkOutput("t2_last0", out_last, 0);
    applyStimulus(8'h00, 1'b0);
    afterEdge();
    checkOutput("t2_code1", out_code, 2);
    checkOutput("t2_msb_code1", m_out_code, 2);
    afterEdge();
    checkOutput("t2_code2", out_code, 7);
    checkOutput("t2_msb_code2", m_out_code, 0);
    checkOutput("t2_last2", out_last, 1);
    afterEdge();
    checkOutput("t2_idle", out_valid, 0);

    // Zero vector
    applyStimulus(8'h00, 1'b1);
    afterEdge();
    checkOutput("t3_code", out_code, 0);
    checkOutput("t3_last", out_last, 1);
    checkOutput("t3_zero", out_zero, 1);
    applyStimulus(8'h00, 1'b0);
    afterEdge();
    checkOutput("t3_idle", out_valid, 0);

    // Backpressure
    applyStimulus(8'b0110_0000, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      afterEdge();
      checkOutput("t4_hold_code", out_code, 5);
      checkOutput("t4_hold_ready", in_ready, 0);
      if (c == 0) applyStimulus(8'hAA, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    afterEdge();
    checkOutput("t4_code6", out_code, 6);
    checkOutput("t4_last", out_last, 1);
    afterEdge();
    checkOutput("t4_idle", out_valid, 0);

    // Back-to-back
    applyStimulus(8'h02, 1'b1);
    afterEdge();
    checkOutput("t5_code1", out_code, 1);
    applyStimulus(8'h80, 1'b1);
    afterEdge();
    checkOutput("t5_valid", out_valid, 1);
    checkOutput("t5_code7", out_code, 7);
    applyStimulus(8'h00, 1'b0);
    afterEdge();
    checkOutput("t5_idle", out_valid, 0);

    // Reset mid-drain
    applyStimulus(8'hFF, 1'b1);
    afterEdge();
    applyStimulus(8'h00, 1'b0);
    afterEdge();
    afterEdge();
    checkOutput("t6_code2", out_code, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    afterEdge();
    checkOutput("t6_ready", in_ready, 1);
    checkOutput("t6_no_stale", out_valid, 0);
    repeat (3) afterEdge();

    // Resume after reset
    applyStimulus(8'h0C, 1'b1);
    afterEdge();
    checkOutput("t7_code", out_code, 2);
    applyStimulus(8'h00, 1'b0);
    repeat (3) afterEdge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
